// File: rtl/uart_pkg.sv
// Shared UART definitions: clocking constants, arbiter state encoding and
// the grant-index width helper used by the transmit arbiter and its selector.
package uart_pkg;

    localparam int CLK_FREQ_HZ  = 12_000_000;
    localparam int BAUD_RATE    = 115_200;
    localparam int BIT_PERIOD   = CLK_FREQ_HZ / BAUD_RATE;

    localparam int DATA_W_DEF   = 8;
    localparam int NUM_REQ_DEF  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_START = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } arb_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GRANT_W = grant_w(NUM_REQ_DEF);

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotate-priority selector: first valid requester at or after ptr, wrapping
// modulo N (N need not be a power of two).
module rr_pick
    import uart_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int GW = grant_w(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [GW-1:0] ptr,
    output logic [GW-1:0] winner,
    output logic          any_valid
);

    logic [GW:0]   sum_s;
    logic [GW-1:0] idx_s;

    // Walk offsets 0..N-1 from ptr; the first hit sticks.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        sum_s     = '0;
        idx_s     = '0;
        for (int k = 0; k < N; k++) begin
            sum_s     = {1'b0, ptr} + (GW+1)'(k);
            idx_s     = (sum_s >= (GW+1)'(N)) ? GW'(sum_s - (GW+1)'(N)) : GW'(sum_s);
            winner    = (valid[idx_s] && !any_valid) ? idx_s : winner;
            any_valid = any_valid | valid[idx_s];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmitter between
// several byte-stream requesters over a tx_start/tx_busy level handshake.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    output logic [grant_w(NUM_REQ)-1:0]  grant_id,
    output logic                         grant_active,
    output logic                         lock_timeout
);

    localparam int GW      = grant_w(NUM_REQ);
    localparam int CNT_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int TO_LAST = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;

    arb_state_e         state_r;
    logic [GW-1:0]      rr_ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               last_r;

    logic [GW-1:0]      win_s;
    logic               any_s;
    logic               g_valid_s;
    logic               g_last_s;
    logic [DATA_W-1:0]  g_data_s;
    logic [GW-1:0]      next_ptr_s;

    rr_pick #(.N(NUM_REQ), .GW(GW)) u_pick (
        .valid     (req_valid),
        .ptr       (rr_ptr_r),
        .winner    (win_s),
        .any_valid (any_s)
    );

    // Mux out the granted requester's lane and the post-release pointer.
    always_comb begin
        g_valid_s = 1'b0;
        g_last_s  = 1'b0;
        g_data_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            g_valid_s = (grant_id == GW'(i)) ? req_valid[i] : g_valid_s;
            g_last_s  = (grant_id == GW'(i)) ? req_last[i]  : g_last_s;
            g_data_s  = (grant_id == GW'(i)) ? req_data[i*DATA_W +: DATA_W] : g_data_s;
        end
        next_ptr_s = (grant_id == GW'(NUM_REQ-1)) ? '0 : grant_id + GW'(1);
    end

    // Arbitration FSM; every output is a register written here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            cnt_r        <= '0;
            last_r       <= 1'b0;
            req_ready    <= '0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            lock_timeout <= 1'b0;
            case (state_r)
                // tx_busy gate also covers a frame left running across reset.
                ST_IDLE: begin
                    if (!tx_busy && any_s) begin
                        grant_id     <= win_s;
                        grant_active <= 1'b1;
                        req_ready    <= NUM_REQ'(1) << win_s;
                        state_r      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tx_data   <= g_data_s;
                    last_r    <= g_last_s;
                    tx_start  <= 1'b1;
                    req_ready <= '0;
                    state_r   <= ST_START;
                end
                ST_START: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state_r  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!tx_busy) begin
                        if (last_r) begin
                            grant_active <= 1'b0;
                            rr_ptr_r     <= next_ptr_s;
                            state_r      <= ST_IDLE;
                        end else if (g_valid_s) begin
                            req_ready <= NUM_REQ'(1) << grant_id;
                            state_r   <= ST_ISSUE;
                        end else begin
                            cnt_r   <= '0;
                            state_r <= ST_HOLD;
                        end
                    end
                end
                // Locked holder is silent; other requesters stay ignored.
                ST_HOLD: begin
                    if (g_valid_s) begin
                        req_ready <= NUM_REQ'(1) << grant_id;
                        state_r   <= ST_ISSUE;
                    end else if ((LOCK_TIMEOUT != 0) && (cnt_r == CNT_W'(TO_LAST))) begin
                        lock_timeout <= 1'b1;
                        grant_active <= 1'b0;
                        rr_ptr_r     <= next_ptr_s;
                        state_r      <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready    <= '0;
                    tx_start     <= 1'b0;
                    grant_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
